// File: rtl/full_adder_half_adder.sv
// Half-adder leaf cell: sum and carry of two single-bit operands.
// Two instances form the core of full_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder from two half adders plus an OR gate.
// The output register is optional; OUT_REG=0 gives a purely combinational cell.
module full_adder #(
    parameter int   OUT_REG       = 1,
    parameter logic RST_VAL_SUM   = 1'b0,
    parameter logic RST_VAL_CARRY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum1,
    output logic carry1
);

    logic s0;
    logic k0;
    logic s1;
    logic k1;
    logic sum_next;
    logic carry_next;

    half_adder u_ha_stage0 (
        .a (a_in),
        .b (b_in),
        .s (s0),
        .c (k0)
    );

    half_adder u_ha_stage1 (
        .a (s0),
        .b (c_in),
        .s (s1),
        .c (k1)
    );

    assign sum_next   = s1;
    assign carry_next = k0 | k1;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic sum_reg;
            logic carry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_reg   <= RST_VAL_SUM;
                    carry_reg <= RST_VAL_CARRY;
                end else begin
                    sum_reg   <= sum_next;
                    carry_reg <= carry_next;
                end
            end

            assign sum1   = sum_reg;
            assign carry1 = carry_reg;
        end else begin : g_out_comb
            // Clock, reset and reset values have no role without the register.
            logic unused_comb_mode;
            assign unused_comb_mode = &{1'b0, clk, rst, RST_VAL_SUM, RST_VAL_CARRY};

            assign sum1   = sum_next;
            assign carry1 = carry_next;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: registered instance (OUT_REG=1) and a
// combinational instance (OUT_REG=0), checked against hand-computed vectors.
module tb_full_adder;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       c;
        logic [1:0] exp;   // {carry, sum}
    } vec_t;

    logic clk;
    logic rst;
    logic a_in;
    logic b_in;
    logic c_in;
    logic sum1;
    logic carry1;

    logic clk_c;
    logic rst_c;
    logic a_c;
    logic b_c;
    logic c_c;
    logic sum_c;
    logic carry_c;

    int checks;
    int errors;

    vec_t sweep [8];
    vec_t truth [8];

    full_adder #(
        .OUT_REG       (1),
        .RST_VAL_SUM   (1'b0),
        .RST_VAL_CARRY (1'b0)
    ) dut_reg (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_in   (c_in),
        .sum1   (sum1),
        .carry1 (carry1)
    );

    full_adder #(
        .OUT_REG       (0),
        .RST_VAL_SUM   (1'b0),
        .RST_VAL_CARRY (1'b0)
    ) dut_comb (
        .clk    (clk_c),
        .rst    (rst_c),
        .a_in   (a_c),
        .b_in   (b_c),
        .c_in   (c_c),
        .sum1   (sum_c),
        .carry1 (carry_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {carry,sum}=%b expected %b at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: {carry,sum}=%b at %0t", name, act, $time);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c);
        a_in = a;
        b_in = b;
        c_in = c;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // a, b, c, {carry, sum}
        sweep[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        sweep[1] = '{1'b1, 1'b0, 1'b0, 2'b01};
        sweep[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        sweep[3] = '{1'b0, 1'b0, 1'b1, 2'b01};
        sweep[4] = '{1'b0, 1'b1, 1'b1, 2'b10};
        sweep[5] = '{1'b1, 1'b1, 1'b0, 2'b10};
        sweep[6] = '{1'b0, 1'b0, 1'b0, 2'b00};
        sweep[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        truth[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        truth[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        truth[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        truth[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        truth[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        truth[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        truth[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        truth[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        clk_c = 1'b0;
        rst_c = 1'b0;
        a_c   = 1'b0;
        b_c   = 1'b0;
        c_c   = 1'b0;

        // Reset with all operands high: outputs must hold the reset values.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("reset_edge1", {carry1, sum1}, 2'b00);
        @(negedge clk);
        check("reset_edge2", {carry1, sum1}, 2'b00);

        // Registered sweep: each result appears one edge after it is applied.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(sweep[i].a, sweep[i].b, sweep[i].c);
            @(negedge clk);
            check($sformatf("sweep[%0d] %b%b%b", i, sweep[i].a, sweep[i].b, sweep[i].c),
                  {carry1, sum1}, sweep[i].exp);
        end

        // Latency: 000 after reset release, then 111 shows up exactly one edge later.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("latency_000", {carry1, sum1}, 2'b00);
        drive(1'b1, 1'b1, 1'b1);
        #1;
        check("latency_hold", {carry1, sum1}, 2'b00);
        @(negedge clk);
        check("latency_111", {carry1, sum1}, 2'b11);

        // Mid-stream reset discards the operand sampled on the reset edge.
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_110", {carry1, sum1}, 2'b10);
        drive(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_111", {carry1, sum1}, 2'b00);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("mid_release_101", {carry1, sum1}, 2'b10);

        // Glitches on a_in between edges must not reach the outputs.
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("glitch_base", {carry1, sum1}, 2'b00);
        a_in = 1'b1;
        #2 a_in = 1'b0;
        #1 check("glitch_low_pulse", {carry1, sum1}, 2'b00);
        #1 a_in = 1'b1;
        #2 a_in = 1'b0;
        #1 check("glitch_sampled_1", {carry1, sum1}, 2'b01);
        @(negedge clk);
        check("glitch_held_1", {carry1, sum1}, 2'b01);
        @(negedge clk);
        check("glitch_sampled_0", {carry1, sum1}, 2'b00);

        // Combinational instance: no clock activity, rst toggled alongside.
        for (int i = 0; i < 8; i++) begin
            a_c   = truth[i].a;
            b_c   = truth[i].b;
            c_c   = truth[i].c;
            rst_c = ~rst_c;
            #1;
            check($sformatf("comb %b%b%b rst=%b", truth[i].a, truth[i].b, truth[i].c, rst_c),
                  {carry_c, sum_c}, truth[i].exp);
        end
        a_c   = 1'b1;
        b_c   = 1'b0;
        c_c   = 1'b1;
        rst_c = 1'b1;
        #1;
        check("comb_rst_high_101", {carry_c, sum_c}, 2'b10);
        rst_c = 1'b0;
        #1;
        check("comb_rst_low_101", {carry_c, sum_c}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
